// File: rtl/mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_io_responder
// Brief    : CPU byte-bus responder: RAM, UART RX/TX, cycle counter, stop flag.
// Revision : 1.0
// ============================================================================
module mem_io_responder #(
   parameter int RAM_AW    = 17,
   parameter int TXF_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_a,
   input  logic [7:0]  mem_dout,
   input  logic        mem_wr,
   output logic [7:0]  mem_din,
   output logic        cpu_rdy,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        prog_stop
);

   localparam int c_PTR_W = (TXF_DEPTH > 1) ? $clog2(TXF_DEPTH) : 1;

   logic [7:0]         r_ram [0:(2**RAM_AW)-1];
   logic [7:0]         r_txf [0:TXF_DEPTH-1];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_PTR_W:0]   r_txf_cnt;
   logic               r_rx_full;
   logic [7:0]         r_rx_byte;
   logic [31:0]        r_cnt;
   logic [31:0]        r_snap;
   logic               r_stop;

   logic               w_txf_full;
   logic               w_rd_ram;
   logic               w_wr_ram;
   logic               w_rd_io;
   logic               w_wr_io;
   logic [2:0]         w_sel;
   logic               w_rx_pop;
   logic               w_rx_load;
   logic               w_tx_push;
   logic               w_tx_pop;
   logic [7:0]         w_tx_byte;
   logic [7:0]         w_io_rdata;
   logic               w_unused;

   assign w_txf_full = (r_txf_cnt == (c_PTR_W+1)'(TXF_DEPTH));
   assign cpu_rdy    = ~w_txf_full & ~r_stop;
   assign w_sel      = mem_a[2:0];

   // Writes are also gated by rst so a transaction cut by reset never lands in RAM.
   assign w_rd_ram  = cpu_rdy & ~mem_a[17] & ~mem_wr;
   assign w_wr_ram  = cpu_rdy & ~mem_a[17] &  mem_wr & ~rst;
   assign w_rd_io   = cpu_rdy &  mem_a[17] & ~mem_wr;
   assign w_wr_io   = cpu_rdy &  mem_a[17] &  mem_wr;

   assign w_rx_pop  = w_rd_io & (w_sel == 3'd0);
   assign rx_ready  = ~r_rx_full;
   assign w_rx_load = rx_valid & rx_ready;

   assign w_tx_push = w_wr_io & (((w_sel == 3'd0) & (mem_dout != 8'h00)) | (w_sel == 3'd4));
   assign w_tx_byte = (w_sel == 3'd4) ? 8'h00 : mem_dout;
   assign tx_valid  = (r_txf_cnt != '0);
   assign tx_data   = r_txf[r_rd_ptr];
   assign w_tx_pop  = tx_valid & tx_ready;
   assign prog_stop = r_stop;

   assign w_unused  = &{1'b0, mem_a[31:18], mem_a[16:3]};

   always_comb begin
      w_io_rdata = 8'h00;
      case (w_sel)
         3'd0:    w_io_rdata = r_rx_full ? r_rx_byte : 8'h00;
         3'd4:    w_io_rdata = r_cnt[7:0];
         3'd5:    w_io_rdata = r_snap[15:8];
         3'd6:    w_io_rdata = r_snap[23:16];
         3'd7:    w_io_rdata = r_snap[31:24];
         default: w_io_rdata = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_wr_ram)
         r_ram[mem_a[RAM_AW-1:0]] <= mem_dout;
   end

   always_ff @(posedge clk) begin
      if (w_tx_push)
         r_txf[r_wr_ptr] <= w_tx_byte;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_din <= 8'h00;
      end else if (w_rd_ram) begin
         mem_din <= r_ram[mem_a[RAM_AW-1:0]];
      end else if (w_rd_io) begin
         mem_din <= w_io_rdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_txf_cnt <= '0;
      end else begin
         if (w_tx_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_tx_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_tx_push, w_tx_pop})
            2'b10:   r_txf_cnt <= r_txf_cnt + 1'b1;
            2'b01:   r_txf_cnt <= r_txf_cnt - 1'b1;
            default: r_txf_cnt <= r_txf_cnt;
         endcase
      end
   end

   // A load can only coincide with a pop while empty, so load wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_full <= 1'b0;
         r_rx_byte <= 8'h00;
      end else if (w_rx_load) begin
         r_rx_full <= 1'b1;
         r_rx_byte <= rx_data;
      end else if (w_rx_pop) begin
         r_rx_full <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= 32'h0;
         r_snap <= 32'h0;
         r_stop <= 1'b0;
      end else begin
         r_cnt <= r_cnt + 32'd1;
         if (w_rd_io && (w_sel == 3'd4)) r_snap <= r_cnt;
         if (w_wr_io && (w_sel == 3'd4)) r_stop <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_io_responder
// Brief    : Directed + random bench for mem_io_responder with queue-based model.
// Revision : 1.0
// ============================================================================
module tb_mem_io_responder;

   localparam int DEPTH = 8;
   localparam logic [31:0] IDLE_A = 32'h0003_0003;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] mem_a;
   logic [7:0]  mem_dout;
   logic        mem_wr;
   logic [7:0]  mem_din;
   logic        cpu_rdy;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        prog_stop;

   mem_io_responder #(.RAM_AW(17), .TXF_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
      .mem_din(mem_din), .cpu_rdy(cpu_rdy), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_ready(rx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .prog_stop(prog_stop)
   );

   always #5 clk = ~clk;

   // Behavioural reference state
   logic [7:0]  ram_m [int];
   logic [7:0]  txq [$];
   bit          m_rx_full;
   logic [7:0]  m_rx_byte;
   logic [31:0] m_cnt;
   logic [31:0] m_snap;
   bit          m_stop;
   logic [7:0]  m_din;

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      txq.delete();
      m_rx_full = 0;
      m_rx_byte = 8'h00;
      m_cnt     = 32'h0;
      m_snap    = 32'h0;
      m_stop    = 0;
      m_din     = 8'h00;
   endtask

   // Applies one clock edge worth of behaviour to the model, using pre-edge inputs.
   task automatic model_edge();
      bit rdy, txpop, rxload, rxpop, push;
      logic [7:0] pb;
      if (rst) begin
         model_reset();
         return;
      end
      rdy    = (txq.size() < DEPTH) && !m_stop;
      txpop  = (txq.size() > 0) && tx_ready;
      rxload = rx_valid && !m_rx_full;
      rxpop  = 0;
      push   = 0;
      pb     = 8'h00;
      if (rdy) begin
         if (!mem_a[17]) begin
            if (mem_wr) ram_m[int'(mem_a[16:0])] = mem_dout;
            else        m_din = ram_m[int'(mem_a[16:0])];
         end else if (mem_wr) begin
            if (mem_a[2:0] == 3'd0 && mem_dout != 8'h00) begin push = 1; pb = mem_dout; end
            if (mem_a[2:0] == 3'd4) begin push = 1; pb = 8'h00; m_stop = 1; end
         end else begin
            case (mem_a[2:0])
               3'd0: begin m_din = m_rx_full ? m_rx_byte : 8'h00; rxpop = 1; end
               3'd4: begin m_din = m_cnt[7:0]; m_snap = m_cnt; end
               3'd5: m_din = m_snap[15:8];
               3'd6: m_din = m_snap[23:16];
               3'd7: m_din = m_snap[31:24];
               default: m_din = 8'h00;
            endcase
         end
      end
      if (txpop) void'(txq.pop_front());
      if (push) txq.push_back(pb);
      if (rxload) begin m_rx_full = 1; m_rx_byte = rx_data; end
      else if (rxpop) m_rx_full = 0;
      m_cnt = m_cnt + 32'd1;
   endtask

   task automatic check_outputs();
      chk("mem_din",   mem_din,   m_din);
      chk("cpu_rdy",   cpu_rdy,   (txq.size() < DEPTH) && !m_stop);
      chk("rx_ready",  rx_ready,  !m_rx_full);
      chk("tx_valid",  tx_valid,  txq.size() > 0);
      if (txq.size() > 0) chk("tx_data", tx_data, txq[0]);
      chk("prog_stop", prog_stop, m_stop);
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d);
      mem_a    = a;
      mem_wr   = wr;
      mem_dout = d;
   endtask

   task automatic async_reset();
      #3 rst = 1'b1;
      #1;
      model_reset();
      check_outputs();
      chk("rst_cpu_rdy", cpu_rdy, 1'b1);
      chk("rst_tx_valid", tx_valid, 1'b0);
      step();
      rst = 1'b0;
   endtask

   initial begin
      bit hs;
      int r;
      logic [7:0] d;
      rst = 1'b1;
      bus(IDLE_A, 1'b0, 8'h00);
      rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
      model_reset();
      step();
      step();
      chk("reset_din", mem_din, 8'h00);
      chk("reset_rx_ready", rx_ready, 1'b1);
      chk("reset_prog_stop", prog_stop, 1'b0);
      rst = 1'b0;

      // RAM write then read back
      bus(32'h0000_0010, 1'b1, 8'hA5); step();
      bus(32'h0000_0010, 1'b0, 8'h00); step();
      chk("ram_rd_a5", mem_din, 8'hA5);

      // RX holding register
      bus(IDLE_A, 1'b0, 8'h00);
      rx_valid = 1'b1; rx_data = 8'h41; step();
      rx_valid = 1'b0;
      chk("rx_full", rx_ready, 1'b0);
      bus(32'h0003_0000, 1'b0, 8'h00); step();
      chk("rx_rd1", mem_din, 8'h41);
      chk("rx_ready_back", rx_ready, 1'b1);
      step();
      chk("rx_rd2", mem_din, 8'h00);

      // TX FIFO fill, back-pressure, drain
      tx_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus(32'h0003_0000, 1'b1, 8'(8'h31 + i)); step();
      end
      chk("txf_full_rdy", cpu_rdy, 1'b0);
      bus(32'h0003_0000, 1'b1, 8'h39); step();
      chk("txf_held_rdy", cpu_rdy, 1'b0);
      bus(IDLE_A, 1'b0, 8'h00);
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("tx_order", tx_data, 32'h31 + i);
         step();
         if (i == 0) chk("rdy_after_pop", cpu_rdy, 1'b1);
      end
      chk("tx_drained", tx_valid, 1'b0);

      // Random phase over a pre-written RAM window
      tx_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         bus(32'h0000_0100 + 32'(i), 1'b1, 8'($urandom)); step();
      end
      for (int n = 0; n < 500; n++) begin
         r = $urandom_range(0, 9);
         d = 8'($urandom);
         case (r)
            0, 1, 2: bus({14'($urandom), 1'b0, 17'(17'h100 + $urandom_range(0, 15))}, 1'b0, d);
            3, 4:    bus({14'($urandom), 1'b0, 17'(17'h100 + $urandom_range(0, 15))}, 1'b1, d);
            5:       bus({14'($urandom), 1'b1, 14'($urandom), 3'd0}, 1'b0, d);
            6:       bus({14'($urandom), 1'b1, 14'($urandom), 3'(4 + $urandom_range(0, 3))}, 1'b0, d);
            7:       bus({14'($urandom), 1'b1, 14'($urandom), 3'd0}, 1'b1, ($urandom_range(0, 3) == 0) ? 8'h00 : d);
            8:       bus({14'($urandom), 1'b1, 14'($urandom), 3'($urandom_range(1, 3))}, 1'b0, d);
            default: bus({14'($urandom), 1'b1, 14'($urandom), 3'd1}, 1'b1, d);
         endcase
         tx_ready = ($urandom_range(0, 2) != 0);
         hs = rx_valid && rx_ready;
         step();
         if (hs || !rx_valid) begin
            rx_valid = ($urandom_range(0, 3) == 0);
            rx_data  = 8'($urandom);
         end
      end
      rx_valid = 1'b0;

      // Counter snapshot after 0x123 edges from reset release
      bus(IDLE_A, 1'b0, 8'h00);
      async_reset();
      for (int i = 0; i < 32'h123; i++) step();
      bus(32'h0003_0004, 1'b0, 8'h00); step();
      chk("snap_b0", mem_din, 8'h23);
      bus(32'h0003_0005, 1'b0, 8'h00); step();
      chk("snap_b1", mem_din, 8'h01);
      bus(32'h0003_0006, 1'b0, 8'h00); step();
      chk("snap_b2", mem_din, 8'h00);
      bus(32'h0003_0007, 1'b0, 8'h00); step();
      chk("snap_b3", mem_din, 8'h00);

      // Zero filter, program stop, draining after stop
      tx_ready = 1'b0;
      bus(32'h0003_0000, 1'b1, 8'h00); step();
      chk("zero_no_push", tx_valid, 1'b0);
      bus(32'h0003_0000, 1'b1, 8'h55); step();
      bus(32'h0003_0004, 1'b1, 8'h77); step();
      chk("stop_set", prog_stop, 1'b1);
      chk("stop_rdy", cpu_rdy, 1'b0);
      bus(32'h0000_0010, 1'b1, 8'hEE); step();
      tx_ready = 1'b1; step();
      chk("stop_zero_byte", tx_data, 8'h00);
      chk("stop_tx_valid", tx_valid, 1'b1);
      tx_ready = 1'b0; step();

      // Reset with FIFO non-empty; RAM survives
      async_reset();
      bus(32'h0000_0010, 1'b0, 8'h00); step();
      chk("ram_survives", mem_din, 8'hA5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire
